// File: rtl/dma_wr_beat_fifo.sv
// dma_wr_beat_fifo: wide write-beat FIFO feeding the DMA width downsizer.
// Optional build macro DMA_WBUF_ZERO_STRB_DROP_EN: handshake but discard beats whose strobes are all zero.
module dma_wr_beat_fifo #(
    parameter int DWIDTH_S = 256,
    parameter int DWADDR   = 32,
    parameter int DEPTH    = 4
) (
    input  logic                       xclk,
    input  logic                       xreset_n,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [DWIDTH_S-1:0]        wdata,
    input  logic [DWADDR-1:0]          waddr,
    input  logic [DWIDTH_S/8-1:0]      wstrb,
    output logic                       mwrite,
    output logic [DWIDTH_S-1:0]        mdata,
    output logic [31:0]                maddr,
    output logic [DWIDTH_S/8-1:0]      mwstrb,
    input  logic                       mready,
    input  logic                       saccept,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [DWIDTH_S-1:0]   mem_data [DEPTH];
    logic [DWADDR-1:0]     mem_addr [DEPTH];
    logic [DWIDTH_S/8-1:0] mem_strb [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  store;
    logic                  pop;

    assign wready = level != (AW+1)'(DEPTH);
    assign mwrite = level != '0;
    assign push   = wvalid & wready;
    assign pop    = mwrite & mready & saccept;
`ifdef DMA_WBUF_ZERO_STRB_DROP_EN
    assign store  = push & (|wstrb);
`else
    assign store  = push;
`endif

    // head entry is presented straight from storage and forced to zero when empty
    always_comb begin
        mdata  = mwrite ? mem_data[rd_ptr] : '0;
        maddr  = mwrite ? 32'(mem_addr[rd_ptr]) : '0;
        mwstrb = mwrite ? mem_strb[rd_ptr] : '0;
    end

    // storage write at the write pointer; contents are don't-care after reset
    always_ff @(posedge xclk) begin
        if (store) begin
            mem_data[wr_ptr] <= wdata;
            mem_addr[wr_ptr] <= waddr;
            mem_strb[wr_ptr] <= wstrb;
        end
    end

    // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge xclk or negedge xreset_n) begin
        if (!xreset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (store && !pop) level <= level + 1'b1;
            else if (!store && pop) level <= level - 1'b1;
        end
    end
endmodule

// File: tb/tb_dma_wr_beat_fifo.sv
// tb_dma_wr_beat_fifo: randomized bench for dma_wr_beat_fifo against a queue reference model.
module tb_dma_wr_beat_fifo;
    localparam int DEPTH = 4;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  a;
        logic [31:0]  s;
    } beat_t;

    logic         xclk = 0;
    logic         xreset_n = 0;
    logic         wvalid = 0;
    logic         wready;
    logic [255:0] wdata = '0;
    logic [31:0]  waddr = '0;
    logic [31:0]  wstrb = '0;
    logic         mwrite;
    logic [255:0] mdata;
    logic [31:0]  maddr;
    logic [31:0]  mwstrb;
    logic         mready = 0;
    logic         saccept = 0;
    logic [2:0]   level;

    beat_t q[$];
    int n_tests = 0;
    int n_fail = 0;
    int max_level = 0;

    dma_wr_beat_fifo #(.DWIDTH_S(256), .DWADDR(32), .DEPTH(DEPTH)) dut (
        .xclk(xclk), .xreset_n(xreset_n), .wvalid(wvalid), .wready(wready),
        .wdata(wdata), .waddr(waddr), .wstrb(wstrb), .mwrite(mwrite),
        .mdata(mdata), .maddr(maddr), .mwstrb(mwstrb), .mready(mready),
        .saccept(saccept), .level(level)
    );

    always #5 xclk = ~xclk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        beat_t h;
        h = '{d: '0, a: '0, s: '0};
        if (q.size() > 0) h = q[0];
        check({tag, ".wready"}, 256'(wready), 256'(q.size() < DEPTH));
        check({tag, ".mwrite"}, 256'(mwrite), 256'(q.size() > 0));
        check({tag, ".level"}, 256'(level), 256'(q.size()));
        check({tag, ".mdata"}, mdata, h.d);
        check({tag, ".maddr"}, 256'(maddr), 256'(h.a));
        check({tag, ".mwstrb"}, 256'(mwstrb), 256'(h.s));
        if (q.size() > max_level) max_level = q.size();
    endtask

    // one clock: drive inputs, decide handshakes from the model, advance model, check at the falling edge
    task automatic cyc(input string tag, input logic v, input logic [31:0] a, input logic [31:0] s,
                       input logic mr, input logic sa);
        logic psh, pp, keep;
        beat_t b;
        b.d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        b.a = a;
        b.s = s;
        wvalid = v; wdata = b.d; waddr = a; wstrb = s; mready = mr; saccept = sa;
        psh = v && q.size() < DEPTH;
        pp = q.size() > 0 && mr && sa;
`ifdef DMA_WBUF_ZERO_STRB_DROP_EN
        keep = s != 0;
`else
        keep = 1'b1;
`endif
        @(posedge xclk);
        if (pp) void'(q.pop_front());
        if (psh && keep) q.push_back(b);
        @(negedge xclk);
        check_all(tag);
    endtask

    initial begin
        @(negedge xclk);
        check_all("reset");
        xreset_n = 1;
        @(negedge xclk);
        check_all("post_reset");

        // single beat, eight slices then the last one accepted
        cyc("single_push", 1, 32'h1000, 32'hffff_ffff, 0, 0);
        for (int i = 0; i < 7; i++) cyc("single_hold", 0, 0, 0, 1, 0);
        cyc("single_pop", 0, 0, 0, 1, 1);
        cyc("single_idle", 0, 0, 0, 1, 0);

        // fill with five back-to-back beats, then one pop and a retry
        for (int i = 0; i < 5; i++) cyc("fill", 1, 32'h2000 + 32'(i * 32), $urandom(), 0, 0);
        cyc("fill_pop", 1, 32'h2080, 32'h1, 1, 1);
        cyc("fill_retry", 1, 32'h2080, 32'h1, 0, 0);

        // stall: saccept without mready holds the head
        for (int i = 0; i < 3; i++) cyc("stall", 0, 0, 0, 0, 1);
        cyc("stall_release", 0, 0, 0, 1, 1);

        // drain to level 2 and push+pop together
        while (q.size() > 2) cyc("drain", 0, 0, 0, 1, 1);
        cyc("push_pop", 1, 32'h3000, 32'hf0f0_f0f0, 1, 1);
        cyc("push_pop2", 1, 32'h3020, 32'h0f0f_0f0f, 1, 1);

        // zero-strobe beat
        while (q.size() > 0) cyc("drain0", 0, 0, 0, 1, 1);
        cyc("zero_strb", 1, 32'h4000, 32'h0, 0, 0);
        while (q.size() > 0) cyc("drain1", 0, 0, 0, 1, 1);

        // pointer wrap with incrementing addresses and random mready
        for (int i = 0; i < 10; ) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            if (v && q.size() < DEPTH) begin
                cyc("wrap", 1, 32'h5000 + 32'(i * 32), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                i++;
            end else cyc("wrap", v, 32'hdead_0000, $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 40 && q.size() > 0; i++) cyc("wrap_drain", 0, 0, 0, 1'($urandom_range(0, 1)), 1);

        // fully random traffic
        for (int i = 0; i < 400; i++)
            cyc("rand", 1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom(),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));

        // reset with three entries queued, asserted between clock edges
        while (q.size() > 0) cyc("pre_rst_drain", 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc("pre_rst_fill", 1, 32'h6000 + 32'(i * 32), 32'hffff_ffff, 0, 0);
        wvalid = 0; mready = 0; saccept = 0;
        #2 xreset_n = 0;
        q.delete();
        #1 check_all("async_rst");
        @(negedge xclk);
        check_all("rst_held");
        xreset_n = 1;
        cyc("rst_new_head", 1, 32'h7000, 32'hffff_ffff, 0, 0);
        cyc("rst_new_pop", 0, 0, 0, 1, 1);

        check("max_level", 256'(max_level <= DEPTH), 256'(1));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/dma_wr_beat_fifo.md
# dma_wr_beat_fifo

Wide write-beat buffer that sits directly upstream of the DMA width downsizer. It accepts full-width write beats (data, address, byte strobes) from the DMA write engine and stores them in a small FIFO. It presents the head entry to the downsizer on the `mwrite`/`mdata`/`maddr`/`mwstrb` bus and holds it stable until the downsizer reports the last narrow slice accepted. This decouples the engine from the DWM-cycle serialisation of each wide beat.

## Interface
- `DWIDTH_S`, 256: wide beat data width in bits; a multiple of 8.
- `DWADDR`, 32: address width.
- `DEPTH`, 4: FIFO entries; a power of two, at least 2.
- `xclk` in 1: clock; all state updates on rising edge.
- `xreset_n` in 1: reset; asynchronous, active-low.
- `wvalid` in 1: engine offers a beat.
- `wready` out 1: buffer can accept; equals `!full`.
- `wdata` in DWIDTH_S: beat data.
- `waddr` in DWADDR: beat address.
- `wstrb` in DWIDTH_S/8: beat byte strobes.
- `mwrite` out 1: head entry valid; equals `!empty`.
- `mdata` out DWIDTH_S: head data; 0 when empty.
- `maddr` out 32: head address, zero-extended from DWADDR; 0 when empty.
- `mwstrb` out DWIDTH_S/8: head strobes; 0 when empty.
- `mready` in 1: downstream slave ready (the same signal the downsizer sees).
- `saccept` in 1: from the downsizer; high while its last slice is presented.
- `level` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH-entry register array with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus the occupancy counter `level`.
- Push: `push = wvalid & wready`. The entry is written at the write pointer, and the write pointer and `level` increment.
- Pop: `pop = mwrite & mready & saccept`. The read pointer increments and `level` decrements.
  - `saccept` without `mready` does not pop, because the final slice has not been taken.
  - `saccept` while empty is ignored.
- Push and pop in the same cycle: `level` is unchanged and both pointers advance.
- Full (`level == DEPTH`): `wready = 0` and `wvalid` is ignored. There is no same-cycle bypass, so a pop in that cycle frees a slot visible in the next cycle.
- Empty (`level == 0`): `mwrite = 0` and `mdata`, `maddr`, `mwstrb` are forced to 0.
- Head stability: while `mwrite = 1` and no pop occurs, `mdata`, `maddr` and `mwstrb` hold. The downsizer's slice counter depends on this.
- No reordering. Beats leave in push order.

## Timing
- Reset (asynchronous assert): pointers = 0, `level` = 0, `mwrite` = 0, `wready` = 1, `mdata`, `maddr` and `mwstrb` = 0. Storage contents need not be cleared.
- Reset mid-beat: all queued and partially serialised beats are discarded. After release, the first push appears as a new head.
- Latency: a push in cycle N makes the entry visible on `mwrite`/`m*` in cycle N+1 when the FIFO was empty.
- After a pop in cycle N, the next entry (if any) is presented in cycle N+1.
- Sustained throughput to the downsizer: one wide beat per DWM cycles when `mready` is held high. `mwrite` stays high across back-to-back beats, with no bubble between them.
- `wready`, `mwrite` and `level` are derived from registered state only and carry no combinational path from inputs.
- `m*` outputs are a mux of registered storage indexed by the read pointer.

## Configuration
- `DMA_WBUF_ZERO_STRB_DROP_EN` defined:
  - A pushed beat whose `wstrb` is all zero is handshaken (`wready` behaves normally) but is not stored.
  - Pointers and `level` are unchanged, so no empty write reaches the bus.
- Macro undefined: every handshaken beat is stored and forwarded, including all-zero-strobe beats.

## Test plan
- Single beat: push `waddr=0x1000`, `wdata` pattern A, `wstrb` all ones into an empty FIFO.
  - `mwrite` rises one cycle later with `maddr=0x1000`.
  - Hold `mready=1` and pulse `saccept` on the 8th cycle (DWIDTH_S=256, 32-bit downstream): pop, `mwrite` returns to 0 next cycle, `level` returns to 0.
- Fill: push 5 beats back-to-back with no pops, DEPTH=4.
  - `wready` drops after the 4th beat and the 5th is held off.
  - The engine retries; after one pop, `wready=1` in the next cycle and the 5th beat is accepted.
- Stall: with head valid, drive `saccept=1` and `mready=0` for 3 cycles.
  - No pop; `level` and head outputs unchanged.
  - Raise `mready` and the pop occurs in that cycle.
- Simultaneous push and pop at `level=2`: `level` stays 2 and the output order matches the push order.
- Pointer wrap: stream 10 beats with incrementing addresses through DEPTH=4 under random `mready`. Output addresses must be exactly in order, and `level` never exceeds 4 or goes negative.
- Reset and macro:
  - Assert `xreset_n=0` with 3 entries queued: `mwrite`, `level` and `m*` go to 0 immediately, `wready` goes to 1.
  - With `DMA_WBUF_ZERO_STRB_DROP_EN` defined, a push with `wstrb=0` leaves `level` at 0 and `mwrite` at 0.
